// File: rtl/bm_encode_sequencer.sv
// Sequencer for the bitmatrix-multiply encoder: walks (m,k) reads, XOR-accumulates the
// returned products and hands each finished parity packet out on a valid/ready port.
module bm_encode_sequencer #(
    parameter int K_MAX         = 128,
    parameter int K_MIN         = 2,
    parameter int M_MAX         = 128,
    parameter int M_MIN         = 2,
    parameter int W             = 4,
    parameter int PACKET_LENGTH = 2,
    parameter int IW            = $clog2((K_MAX > M_MAX) ? K_MAX : M_MAX) + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [IW-1:0]                 k_cfg,
    input  logic [IW-1:0]                 m_cfg,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err,
    output logic                          rd_en,
    output logic [IW-1:0]                 rd_k_idx,
    output logic [IW-1:0]                 rd_m_idx,
    input  logic [W*PACKET_LENGTH-1:0]    mult_product,
    output logic [W*PACKET_LENGTH-1:0]    parity_out,
    output logic [IW-1:0]                 parity_idx,
    output logic                          parity_vld,
    input  logic                          parity_rdy
);

    localparam int PW = W * PACKET_LENGTH;
    localparam logic [IW-1:0] K_LO    = IW'(K_MIN);
    localparam logic [IW-1:0] K_HI    = IW'(K_MAX);
    localparam logic [IW-1:0] M_LO    = IW'(M_MIN);
    localparam logic [IW-1:0] M_HI    = IW'(M_MAX);
    localparam logic [IW-1:0] IDX_ONE = IW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] k_reg;
    logic [IW-1:0] m_reg;
    logic [IW-1:0] k_idx;
    logic [IW-1:0] m_idx;
    logic          prod_vld;
    logic          prod_first;
    logic [PW-1:0] acc;
    logic [PW-1:0] acc_nxt;
    logic          cfg_ok;
    logic          k_last;
    logic          m_last;

    assign cfg_ok = (k_cfg >= K_LO) && (k_cfg <= K_HI) &&
                    (m_cfg >= M_LO) && (m_cfg <= M_HI);
    assign k_last = (k_idx == (k_reg - IDX_ONE));
    assign m_last = (m_idx == (m_reg - IDX_ONE));

    // The first product of a parity overwrites acc, so no clear cycle is needed between parities.
    assign acc_nxt = prod_vld ? (prod_first ? mult_product : (acc ^ mult_product)) : acc;

    assign busy       = (state != IDLE);
    assign rd_en      = (state == ISSUE);
    assign rd_k_idx   = k_idx;
    assign rd_m_idx   = m_idx;
    assign parity_vld = (state == OUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && cfg_ok) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (k_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = OUT;
            end
            OUT: begin
                if (parity_rdy) begin
                    state_nxt = m_last ? IDLE : ISSUE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg      <= '0;
            m_reg      <= '0;
            k_idx      <= '0;
            m_idx      <= '0;
            prod_vld   <= 1'b0;
            prod_first <= 1'b0;
            acc        <= '0;
            parity_out <= '0;
            parity_idx <= '0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            done       <= 1'b0;
            cfg_err    <= 1'b0;
            prod_vld   <= rd_en;
            prod_first <= rd_en && (k_idx == '0);
            acc        <= acc_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            k_reg <= k_cfg;
                            m_reg <= m_cfg;
                            k_idx <= '0;
                            m_idx <= '0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    k_idx <= k_last ? '0 : (k_idx + IDX_ONE);
                end
                DRAIN: begin
                    // The last product lands this cycle, so capture the combined value.
                    parity_out <= acc_nxt;
                    parity_idx <= m_idx;
                end
                OUT: begin
                    if (parity_rdy) begin
                        if (m_last) begin
                            done <= 1'b1;
                        end else begin
                            m_idx <= m_idx + IDX_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bm_encode_sequencer.sv
// Directed bench for bm_encode_sequencer with a bitmatrix-multiply model and
// scoreboards for the read sequence and the parity packets.
module tb_bm_encode_sequencer;

    localparam int IW = 8;
    localparam int PW = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [IW-1:0] k_cfg;
    logic [IW-1:0] m_cfg;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic          rd_en;
    logic [IW-1:0] rd_k_idx;
    logic [IW-1:0] rd_m_idx;
    logic [PW-1:0] mult_product;
    logic [PW-1:0] parity_out;
    logic [IW-1:0] parity_idx;
    logic          parity_vld;
    logic          parity_rdy;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int start_cyc    = 0;
    int max_k        = 0;
    int done_cyc     = 0;
    logic vld_prev   = 1'b0;
    logic blk_mode   = 1'b0;   // 0: identity blocks, 1: all-ones blocks

    logic [15:0] exp_rd_q[$];   // {m, k} of each expected read
    logic [15:0] exp_par_q[$];  // {parity_idx, parity_out}
    int          vld_cyc_q[$];
    logic [PW-1:0] data_mem[4];

    bm_encode_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .k_cfg        (k_cfg),
        .m_cfg        (m_cfg),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err),
        .rd_en        (rd_en),
        .rd_k_idx     (rd_k_idx),
        .rd_m_idx     (rd_m_idx),
        .mult_product (mult_product),
        .parity_out   (parity_out),
        .parity_idx   (parity_idx),
        .parity_vld   (parity_vld),
        .parity_rdy   (parity_rdy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Rows are PL=2 bits, row r at bits [2r+1:2r]; block bit (i,j) selects data row j into out row i.
    function automatic logic [PW-1:0] mul_model(input logic mode, input logic [IW-1:0] k);
        logic [PW-1:0] d;
        logic [PW-1:0] r;
        d = mode ? 8'hFF : data_mem[k[1:0]];
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (mode || (i == j)) begin
                    r[2*i +: 2] = r[2*i +: 2] ^ d[2*j +: 2];
                end
            end
        end
        return r;
    endfunction

    // Multiply unit: product valid exactly one cycle after the read strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_product <= '0;
        end else if (rd_en) begin
            mult_product <= mul_model(blk_mode, rd_k_idx);
        end
    end

    // Monitor: cycle 1 is the cycle in which start is held high.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en) begin
                if (int'(rd_k_idx) > max_k) max_k = int'(rd_k_idx);
                if (exp_rd_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $error("FAIL rd_unexpected: observed m=%0d k=%0d expected no read", rd_m_idx, rd_k_idx);
                end else begin
                    check("rd_seq", {rd_m_idx, rd_k_idx}, exp_rd_q.pop_front());
                end
            end
            if (parity_vld && parity_rdy) begin
                if (exp_par_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $error("FAIL par_unexpected: observed idx=%0d data=%0h expected none", parity_idx, parity_out);
                end else begin
                    check("parity", {parity_idx, parity_out}, exp_par_q.pop_front());
                end
            end
            if (parity_vld && !vld_prev) vld_cyc_q.push_back(cyc - start_cyc + 1);
            vld_prev = parity_vld;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input int kk, input int mm, input logic [PW-1:0] par);
        for (int m = 0; m < mm; m++) begin
            for (int k = 0; k < kk; k++) exp_rd_q.push_back({8'(m), 8'(k)});
            exp_par_q.push_back({8'(m), par});
        end
    endtask

    task automatic pulse_start(input int kk, input int mm);
        k_cfg     = 8'(kk);
        m_cfg     = 8'(mm);
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int c);
        logic seen;
        seen = 1'b0;
        c    = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                c    = cyc - start_cyc + 1;
            end
        end
        check("done_seen", seen, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_cfg_err"}, cfg_err, 1'b0);
        check({tag, "_rd_en"}, rd_en, 1'b0);
        check({tag, "_rd_k"}, rd_k_idx, 8'd0);
        check({tag, "_rd_m"}, rd_m_idx, 8'd0);
        check({tag, "_pout"}, parity_out, 8'd0);
        check({tag, "_pidx"}, parity_idx, 8'd0);
        check({tag, "_pvld"}, parity_vld, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic seen;
        rst_n      = 1'b0;
        start      = 1'b0;
        k_cfg      = '0;
        m_cfg      = '0;
        parity_rdy = 1'b1;
        data_mem[0] = 8'h39;  // rows {1,2,3,0}
        data_mem[1] = 8'hDA;  // rows {2,2,1,3}
        data_mem[2] = 8'h5A;
        data_mem[3] = 8'h0F;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Identity blocks, k=2 m=2: parity rows {3,0,2,3} = 8'hE3
        blk_mode = 1'b0;
        vld_cyc_q.delete();
        push_run(2, 2, 8'hE3);
        pulse_start(2, 2);
        check("t1_busy", busy, 1'b1);
        check("t1_no_err", cfg_err, 1'b0);
        check("t1_first_rd", {rd_en, rd_m_idx, rd_k_idx}, {1'b1, 8'd0, 8'd0});
        wait_done(50, done_cyc);
        check("t1_done_cyc", done_cyc, 10);
        check("t1_vld_count", vld_cyc_q.size(), 2);
        if (vld_cyc_q.size() == 2) begin
            check("t1_vld_cyc0", vld_cyc_q[0], 5);
            check("t1_vld_cyc1", vld_cyc_q[1], 9);
        end
        tick();
        check("t1_done_pulse", done, 1'b0);
        check("t1_idle", busy, 1'b0);

        // Backpressure: hold parity_rdy low for 10 cycles in OUT
        parity_rdy = 1'b0;
        push_run(2, 2, 8'hE3);
        pulse_start(2, 2);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (parity_vld) seen = 1'b1;
            else tick();
        end
        check("bp_vld_seen", seen, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_vld", parity_vld, 1'b1);
            check("bp_hold_data", {parity_idx, parity_out}, {8'd0, 8'hE3});
            check("bp_no_rd", rd_en, 1'b0);
            tick();
        end
        parity_rdy = 1'b1;
        tick();
        check("bp_resume", {rd_en, rd_m_idx, rd_k_idx}, {1'b1, 8'd1, 8'd0});
        wait_done(50, done_cyc);

        // Config errors
        pulse_start(1, 2);
        check("err_k1_pulse", cfg_err, 1'b1);
        check("err_k1_busy", busy, 1'b0);
        tick();
        check("err_k1_once", cfg_err, 1'b0);
        pulse_start(129, 2);
        check("err_k129_pulse", cfg_err, 1'b1);
        check("err_k129_busy", busy, 1'b0);
        pulse_start(2, 129);
        check("err_m129_pulse", cfg_err, 1'b1);
        tick();

        // Max k, all-ones blocks, data rows all 3: every product is zero
        blk_mode = 1'b1;
        max_k    = 0;
        push_run(128, 2, 8'h00);
        pulse_start(128, 2);
        wait_done(600, done_cyc);
        check("max_k_reached", max_k, 127);
        tick();

        // Reset in the middle of ISSUE at k_idx=1
        blk_mode = 1'b0;
        exp_rd_q.push_back({8'd0, 8'd0});
        pulse_start(4, 2);
        tick();
        check("rst_pre_k", rd_k_idx, 8'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("rst_rd_q_empty", exp_rd_q.size(), 0);
        check_all_zero("rst_after");

        // Clean restart with k=4; start pulsed while busy must be ignored
        push_run(4, 2, 8'hB6);
        pulse_start(4, 2);
        repeat (2) tick();
        k_cfg = 8'd3;
        m_cfg = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_no_err", cfg_err, 1'b0);
        check("busy_start_busy", busy, 1'b1);
        wait_done(100, done_cyc);
        tick();

        check("end_rd_q_empty", exp_rd_q.size(), 0);
        check("end_par_q_empty", exp_par_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bm_encode_sequencer.md
Name: bm_encode_sequencer

Overview:
Sequences the bitmatrix-multiply datapath to produce M parity packets from K data packets. For each parity index m it computes XOR over k of (bitmatrix block (m,k) times data packet k). Each cycle it issues one (m,k) read to the external data/bitmatrix stores. It accumulates the returned multiply products in a W x PACKET_LENGTH register and presents each finished parity packet on a valid/ready output. It sits between the engine's top-level control, the stores, and the combinational bitmatrix-multiply unit.

Parameters:
K_MAX, 128, max data packets per stripe
K_MIN, 2, min legal k_cfg
M_MAX, 128, max parity packets per stripe
M_MIN, 2, min legal m_cfg
W, 4, word width; rows per packet and bitmatrix block size
PACKET_LENGTH, 2, bits per packet row
IW, $clog2(K_MAX>M_MAX?K_MAX:M_MAX)+1, index/config width (derived, don't override)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
start  in  1  one-cycle start request; sampled only in IDLE
k_cfg  in  IW  number of data packets, sampled on accepted start
m_cfg  in  IW  number of parity packets, sampled on accepted start
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the last parity is accepted
cfg_err  out  1  one-cycle pulse when start is rejected
rd_en  out  1  read strobe to the data/bitmatrix stores
rd_k_idx  out  IW  data packet index, and bitmatrix column-block index
rd_m_idx  out  IW  parity / bitmatrix row-block index
mult_product  in  [PACKET_LENGTH-1:0] x W  multiply-unit output; valid exactly 1 cycle after rd_en
parity_out  out  [PACKET_LENGTH-1:0] x W  accumulated parity packet
parity_idx  out  IW  m index of parity_out
parity_vld  out  1  parity_out valid
parity_rdy  in  1  downstream accept

Behaviour:
- Reset (async assert, sync deassert by external reset logic):
  - state=IDLE.
  - All outputs 0, including acc, parity_out, the indices and prod_vld.
- States: IDLE, ISSUE, DRAIN, OUT.
- IDLE:
  - On start, check K_MIN<=k_cfg<=K_MAX and M_MIN<=m_cfg<=M_MAX.
  - Legal: latch k/m, k_idx=0, m_idx=0, go to ISSUE.
  - Illegal: cfg_err pulses next cycle, stay IDLE.
  - start in any non-IDLE state is ignored (no error).
- ISSUE:
  - rd_en=1 with rd_k_idx=k_idx and rd_m_idx=m_idx; k_idx increments every cycle.
  - When k_idx==k-1, issue that read, then k_idx=0 and go to DRAIN.
  - No stalls inside ISSUE.
- Accumulate:
  - prod_vld is rd_en delayed 1 cycle; prod_first marks the product for k_idx==0.
  - When prod_vld: acc = prod_first ? mult_product : acc ^ mult_product (per row, bitwise).
- DRAIN:
  - One cycle; rd_en=0; the last product is accumulated.
  - Next state is OUT, with parity_out=acc and parity_idx=m_idx registered on entry.
- OUT:
  - parity_vld=1; parity_out and parity_idx are held stable until parity_rdy.
  - On parity_vld&&parity_rdy: parity_vld=0.
  - If m_idx==m-1: done pulses 1 cycle, go to IDLE.
  - Else: m_idx++, go to ISSUE.
- Latency:
  - parity_vld rises k+2 cycles after the first ISSUE cycle (k issue cycles, DRAIN, register into OUT).
  - Back-to-back with parity_rdy=1: each parity costs k+2 cycles.
  - The first rd_en is 1 cycle after start.
- Boundary conditions:
  - k=K_MAX and m=M_MAX: indices must not overflow (IW has one spare bit).
  - parity_rdy held low indefinitely: OUT holds, no reads are issued, acc is frozen.
  - parity_rdy high before parity_vld: no effect.
  - rst_n asserted mid-stripe: immediate return to IDLE and all outputs cleared, including a pending parity_vld. No done pulse.
- Arithmetic: XOR/GF(2) only; no carries.

Test Plan:
- Identity blocks, k=2, m=2, W=4, PL=2; bench model of the multiply unit; data0 rows {1,2,3,0}, data1 rows {2,2,1,3}, parity_rdy=1.
  - Required: rd_en k-sequence 0,1 per m.
  - Required: parity_out rows {3,0,2,3} for both m; parity_idx 0 then 1; parity_vld at cycles 5 and 9 after start; done 1 cycle after second accept.
- Backpressure: same stimulus, parity_rdy low for 10 cycles in OUT.
  - Required: parity_vld stays high; data and index stable; rd_en=0 throughout; m=1 issue begins the cycle after rdy rises.
- Config errors:
  - start with k_cfg=1 -> cfg_err pulse, busy stays 0.
  - k_cfg=K_MAX+1 -> cfg_err pulse.
  - m_cfg=2, k_cfg=2 -> accepted.
- Max config, k=128, m=2, all-ones blocks, data_k rows all 3.
  - Required: parity rows all 0 (even count); rd_k_idx reaches 127 with no wrap.
- Reset mid-ISSUE: rst_n low at k_idx=1 of m=0 with k=4.
  - Required: all outputs 0 immediately; after release, a new start runs cleanly from m=0, k=0.
- start pulsed while busy: ignored; config and sequence unchanged.
